// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M control sequencer: state encoding,
// configuration entry layout and the sensor init table walked after reset.
package d5m_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CFG_ISSUE = 3'd3,
    ST_CFG_WAIT  = 3'd4,
    ST_RUN       = 3'd5,
    ST_HOST_WAIT = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cfg_entry_t;

  localparam int CFG_DEPTH = 8;

  // Mirror/readout mode, blanking, pixel-clock polarity, then the four colour gains.
  localparam cfg_entry_t CFG_TABLE [CFG_DEPTH] = '{
    '{addr: 8'h20, data: 16'hC000},
    '{addr: 8'h05, data: 16'h0000},
    '{addr: 8'h06, data: 16'h0019},
    '{addr: 8'h0A, data: 16'h8000},
    '{addr: 8'h2B, data: 16'h000B},
    '{addr: 8'h2C, data: 16'h000F},
    '{addr: 8'h2D, data: 16'h000F},
    '{addr: 8'h2E, data: 16'h000B}
  };

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/d5m_sync2.sv
// Two-flop synchronizer for a single asynchronous level (sensor frame-valid).
module d5m_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/d5m_ctrl_sequencer.sv
// D5M control-plane sequencer: sensor reset, init-table walk over I2C, host writes
// and blanking-gated snapshot triggers (snapshot path built only with D5M_SNAPSHOT_EN).
module d5m_ctrl_sequencer
  import d5m_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES  = 5000,
  parameter int unsigned TRIGGER_CYCLES = 4,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        ul1Clock,
  input  logic        ul1Resetn,
  input  logic        ul1Start,
  input  logic        ul1FrameValid,
  output logic        ul1CamResetn,
  output logic        ul1SnapshotTrigger,
  input  logic        ul1SnapReq,
  input  logic        ul1HostWrReq,
  input  logic [7:0]  ul8HostAddr,
  input  logic [15:0] ul16HostData,
  output logic        ul1HostWrAck,
  output logic        ul1I2cReq,
  output logic [7:0]  ul8I2cAddr,
  output logic [15:0] ul16I2cData,
  input  logic        ul1I2cDone,
  input  logic        ul1I2cNack,
  output logic        ul1Ready,
  output logic        ul1Error,
  output logic [2:0]  ul3State
);

  localparam int unsigned RW = cnt_width(RESET_CYCLES);
  localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned IW = cnt_width(CFG_DEPTH);
  localparam int unsigned TW = cnt_width(MAX_RETRY + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CFG_DEPTH - 1);
  localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] retry_q, retry_d;
  logic        camrst_q, camrst_d;
  logic        req_q, req_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;

  logic fv_sync;
  logic done_ok;
  logic done_nack;
  logic host_pend;

  d5m_sync2 u_fv_sync (
    .clk_i  (ul1Clock),
    .rst_ni (ul1Resetn),
    .d_i    (ul1FrameValid),
    .q_o    (fv_sync)
  );

  assign done_ok   = req_q & ul1I2cDone & ~ul1I2cNack;
  assign done_nack = req_q & ul1I2cDone & ul1I2cNack;
  // The host still holds its request during the ack cycle; mask it so it is not served twice.
  assign host_pend = ul1HostWrReq & ~ack_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    set_cnt_d = set_cnt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_d     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        req_d = 1'b0;
        if (ul1Start) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_SETTLE;
          set_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = ST_CFG_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      ST_CFG_ISSUE: begin
        state_d = ST_CFG_WAIT;
        req_d   = 1'b1;
        addr_d  = CFG_TABLE[idx_q].addr;
        data_d  = CFG_TABLE[idx_q].data;
      end
      ST_CFG_WAIT: begin
        if (done_ok) begin
          req_d   = 1'b0;
          retry_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_CFG_ISSUE;
          end
        end else if (done_nack) begin
          req_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_CFG_ISSUE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_RUN: begin
        if (host_pend && !fv_sync) begin
          state_d = ST_HOST_WAIT;
          req_d   = 1'b1;
          addr_d  = ul8HostAddr;
          data_d  = ul16HostData;
          retry_d = '0;
        end
      end
      ST_HOST_WAIT: begin
        // A dropped request here means a NACK was just seen: re-raise after one idle cycle.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (done_ok) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RUN;
        end else if (done_nack) begin
          req_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    camrst_d = !((state_d == ST_IDLE) || (state_d == ST_RESET));
    ready_d  = (state_d == ST_RUN);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge ul1Clock or negedge ul1Resetn) begin
    if (!ul1Resetn) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
      set_cnt_q <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      camrst_q  <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      set_cnt_q <= set_cnt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      camrst_q  <= camrst_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

`ifdef D5M_SNAPSHOT_EN
  localparam int unsigned GW = cnt_width(TRIGGER_CYCLES);
  localparam logic [GW-1:0] TRIG_LAST = GW'(TRIGGER_CYCLES - 1);

  logic          snap_pend_q;
  logic          trig_q;
  logic [GW-1:0] trig_cnt_q;
  logic          fire;

  // Host writes win: a trigger only fires when no host write is waiting.
  assign fire = (state_q == ST_RUN) & ~fv_sync & ~host_pend & ~trig_q & snap_pend_q;

  always_ff @(posedge ul1Clock or negedge ul1Resetn) begin
    if (!ul1Resetn) begin
      snap_pend_q <= 1'b0;
      trig_q      <= 1'b0;
      trig_cnt_q  <= '0;
    end else begin
      if (state_q == ST_ERROR || fire) begin
        snap_pend_q <= 1'b0;
      end else if (ul1SnapReq) begin
        snap_pend_q <= 1'b1;
      end
      if (fire) begin
        trig_q     <= 1'b1;
        trig_cnt_q <= '0;
      end else if (trig_q) begin
        if (trig_cnt_q == TRIG_LAST) begin
          trig_q <= 1'b0;
        end else begin
          trig_cnt_q <= trig_cnt_q + 1'b1;
        end
      end
    end
  end

  assign ul1SnapshotTrigger = trig_q;
`else
  logic unused_snap_req;
  assign unused_snap_req    = ul1SnapReq;
  assign ul1SnapshotTrigger = 1'b0;
`endif

  assign ul1CamResetn = camrst_q;
  assign ul1I2cReq    = req_q;
  assign ul8I2cAddr   = addr_q;
  assign ul16I2cData  = data_q;
  assign ul1HostWrAck = ack_q;
  assign ul1Ready     = ready_q;
  assign ul1Error     = error_q;
  assign ul3State     = state_q;

endmodule

// File: tb/tb_d5m_ctrl_sequencer.sv
// Self-checking bench for d5m_ctrl_sequencer: random NACK patterns and host writes
// against a queue-based model of the expected I2C write stream.
`timescale 1ns/1ps
module tb_d5m_ctrl_sequencer;
  import d5m_pkg::*;

  localparam int RST_C  = 10;
  localparam int SET_C  = 20;
  localparam int TRIG_C = 4;
  localparam int MAXR   = 3;
`ifdef D5M_SNAPSHOT_EN
  localparam int SNAP_EN = 1;
`else
  localparam int SNAP_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fv = 1'b0;
  logic        snap_req = 1'b0;
  logic        host_req = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_data = '0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        cam_rstn, trig, ack, i2c_req, ready, err;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int trig_rise_cyc = -1;
  int req_rise_cyc = -1;
  int trig_w = 0;
  logic trig_prev = 1'b0;
  logic req_prev = 1'b0;
  bit resp_en = 1'b1;
  int nack_cnt [CFG_DEPTH];

  bit          nack_plan [$];
  logic [23:0] wr_log [$];
  int          trig_widths [$];

  always #5 clk = ~clk;

  d5m_ctrl_sequencer #(
    .RESET_CYCLES   (RST_C),
    .SETTLE_CYCLES  (SET_C),
    .TRIGGER_CYCLES (TRIG_C),
    .MAX_RETRY      (MAXR)
  ) dut (
    .ul1Clock           (clk),
    .ul1Resetn          (rst_n),
    .ul1Start           (start),
    .ul1FrameValid      (fv),
    .ul1CamResetn       (cam_rstn),
    .ul1SnapshotTrigger (trig),
    .ul1SnapReq         (snap_req),
    .ul1HostWrReq       (host_req),
    .ul8HostAddr        (host_addr),
    .ul16HostData       (host_data),
    .ul1HostWrAck       (ack),
    .ul1I2cReq          (i2c_req),
    .ul8I2cAddr         (i2c_addr),
    .ul16I2cData        (i2c_data),
    .ul1I2cDone         (i2c_done),
    .ul1I2cNack         (i2c_nack),
    .ul1Ready           (ready),
    .ul1Error           (err),
    .ul3State           (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Passive monitors: trigger pulse widths, request rises, ack pulses.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (trig) begin
      if (!trig_prev) begin
        trig_rise_cyc = cyc;
        trig_w = 1;
      end else begin
        trig_w++;
      end
    end else if (trig_prev) begin
      trig_widths.push_back(trig_w);
      $display("trigger pulse width=%0d cyc=%0d", trig_w, cyc);
    end
    trig_prev = trig;
    if (i2c_req && !req_prev) req_rise_cyc = cyc;
    req_prev = i2c_req;
    if (ack) begin
      ack_cnt++;
      $display("host ack cyc=%0d", cyc);
    end
  end

  // I2C write master model: random latency, NACKs taken from nack_plan.
  always begin
    logic [7:0]  a;
    logic [15:0] d;
    int          lat;
    bit          nk;
    @(posedge clk);
    #1;
    if (resp_en && rst_n && i2c_req) begin
      a = i2c_addr;
      d = i2c_data;
      lat = int'($urandom_range(0, 3));
      for (int k = 0; k < lat; k++) begin
        tick();
        check_eq("i2c_hold", {8'h0, i2c_addr, i2c_data}, {8'h0, a, d});
      end
      nk = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
      i2c_nack = nk;
      i2c_done = 1'b1;
      wr_log.push_back({a, d});
      $display("i2c write addr=0x%02h data=0x%04h nack=%0d cyc=%0d", a, d, nk, cyc);
      tick();
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      check_eq("i2c_req_fall", i2c_req, 1'b0);
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, state, 3'd0);
    check_eq({tag, "_camrstn"}, cam_rstn, 1'b0);
    check_eq({tag, "_i2creq"}, i2c_req, 1'b0);
    check_eq({tag, "_addr"}, i2c_addr, 8'h0);
    check_eq({tag, "_data"}, i2c_data, 16'h0);
    check_eq({tag, "_ack"}, ack, 1'b0);
    check_eq({tag, "_ready"}, ready, 1'b0);
    check_eq({tag, "_error"}, err, 1'b0);
    check_eq({tag, "_trig"}, trig, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    host_req = 1'b0;
    snap_req = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
  endtask

  // Pulses start and walks the init table with nack_cnt[] failures per entry.
  task automatic run_init();
    logic [23:0] exp_log [$];
    bit exp_err;
    int tries;
    int n;
    exp_err = 1'b0;
    nack_plan.delete();
    wr_log.delete();
    for (int e = 0; e < CFG_DEPTH && !exp_err; e++) begin
      tries = (nack_cnt[e] > MAXR) ? MAXR + 1 : nack_cnt[e] + 1;
      for (int t = 0; t < tries; t++) begin
        exp_log.push_back({CFG_TABLE[e].addr, CFG_TABLE[e].data});
        nack_plan.push_back(t < nack_cnt[e]);
      end
      if (nack_cnt[e] > MAXR) exp_err = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("err_clear", err, 1'b0);
    n = 0;
    while (state == 3'd1 && n < 100) begin
      check_eq("camrstn_low", cam_rstn, 1'b0);
      n++;
      tick();
    end
    check_eq("reset_len", n, RST_C);
    check_eq("state_settle", state, 3'd2);
    check_eq("camrstn_settle", cam_rstn, 1'b1);
    n = 0;
    while (state == 3'd2 && n < 200) begin
      n++;
      tick();
    end
    check_eq("settle_len", n, SET_C);
    n = 0;
    while (!ready && !err && n < 3000) begin
      n++;
      tick();
    end
    check_eq("init_done", n < 3000, 1'b1);
    repeat (3) tick();
    check_eq("cfg_count", wr_log.size(), exp_log.size());
    for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++)
      check_eq("cfg_entry", wr_log[i], exp_log[i]);
    check_eq("init_error", err, exp_err);
    check_eq("init_ready", ready, !exp_err);
    check_eq("init_state", state, exp_err ? 3'd7 : 3'd5);
    check_eq("init_camrstn", cam_rstn, 1'b1);
    check_eq("init_i2creq", i2c_req, 1'b0);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d, input int nacks, input int fv_hold);
    int tries;
    int n;
    bit exp_err;
    bit seen_req;
    tries = (nacks > MAXR) ? MAXR + 1 : nacks + 1;
    exp_err = (nacks > MAXR);
    nack_plan.delete();
    wr_log.delete();
    ack_cnt = 0;
    for (int t = 0; t < tries; t++) nack_plan.push_back(t < nacks);
    if (fv_hold > 0) begin
      fv = 1'b1;
      repeat (3) tick();
    end
    host_addr = a;
    host_data = d;
    host_req = 1'b1;
    seen_req = 1'b0;
    for (int k = 0; k < fv_hold; k++) begin
      tick();
      if (i2c_req) seen_req = 1'b1;
    end
    check_eq("hold_off_fv", seen_req, 1'b0);
    if (fv_hold > 0) begin
      fv = 1'b0;
      tick();
      check_eq("fv_gate_e1", i2c_req, 1'b0);
      tick();
      check_eq("fv_gate_e2", i2c_req, 1'b0);
    end
    n = 0;
    while (!ack && !err && n < 500) begin
      n++;
      tick();
    end
    check_eq("host_done", n < 500, 1'b1);
    host_req = 1'b0;
    repeat (4) tick();
    check_eq("host_acks", ack_cnt, exp_err ? 0 : 1);
    check_eq("host_error", err, exp_err);
    check_eq("host_state", state, exp_err ? 3'd7 : 3'd5);
    check_eq("host_count", wr_log.size(), tries);
    foreach (wr_log[i]) check_eq("host_entry", wr_log[i], {a, d});
  endtask

  task automatic snap_test();
    int n;
    trig_widths.delete();
    fv = 1'b1;
    repeat (3) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (5) tick();
    check_eq("trig_during_fv", trig_widths.size() + int'(trig), 0);
    fv = 1'b0;
    repeat (15) tick();
    check_eq("snap_merge_pulses", trig_widths.size(), SNAP_EN);
    foreach (trig_widths[i]) check_eq("snap_merge_width", trig_widths[i], TRIG_C);

    trig_widths.delete();
    nack_plan.delete();
    wr_log.delete();
    ack_cnt = 0;
    trig_rise_cyc = -1;
    host_addr = 8'h1E;
    host_data = 16'h4006;
    host_req = 1'b1;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n = 0;
    while (!ack && n < 500) begin
      n++;
      tick();
    end
    check_eq("prio_ack_seen", n < 500, 1'b1);
    host_req = 1'b0;
    repeat (15) tick();
    check_eq("prio_wr_count", wr_log.size(), 1);
    foreach (wr_log[i]) check_eq("prio_wr_entry", wr_log[i], {8'h1E, 16'h4006});
    check_eq("prio_acks", ack_cnt, 1);
    check_eq("prio_pulses", trig_widths.size(), SNAP_EN);
    foreach (trig_widths[i]) check_eq("prio_width", trig_widths[i], TRIG_C);
    check_eq("snap_after_i2c", trig_rise_cyc > req_rise_cyc, SNAP_EN);
  endtask

  initial begin
    int n;
    int c2;
    apply_reset();

    foreach (nack_cnt[e]) nack_cnt[e] = 0;
    run_init();

    host_write(8'h09, 16'h0400, 0, 10);
    for (int k = 0; k < 6; k++)
      host_write(8'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)) * int'($urandom_range(1, 6)));

    snap_test();

    host_write(8'($urandom), 16'($urandom), 4, 0);

    foreach (nack_cnt[e]) nack_cnt[e] = 0;
    nack_cnt[0] = 4;
    run_init();
    nack_cnt[0] = 0;
    run_init();

    apply_reset();
    nack_cnt[2] = 2;
    run_init();
    c2 = 0;
    foreach (wr_log[i]) if (wr_log[i] == {CFG_TABLE[2].addr, CFG_TABLE[2].data}) c2++;
    check_eq("entry2_issues", c2, 3);

    for (int r = 0; r < 3; r++) begin
      apply_reset();
      foreach (nack_cnt[e])
        nack_cnt[e] = ($urandom_range(0, 7) == 0) ? 4 : int'($urandom_range(0, 2));
      run_init();
    end

    resp_en = 1'b0;
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state != 3'd4 && n < 200) begin
      n++;
      tick();
    end
    check_eq("reach_cfg_wait", state, 3'd4);
    check_eq("req_in_cfg_wait", i2c_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_midrst_state", state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d5m_ctrl_sequencer.md
# d5m_ctrl_sequencer

Control-plane sequencer for the TRDB_D5M camera daughter board; it sits on the driver side of the D5M interface, next to the pixel capture path. It sequences sensor reset, walks a fixed register-configuration table through a separate I2C write master, and then serves runtime host register writes. In the run phase it also issues snapshot trigger pulses. Every sensor-side register write and trigger is gated to vertical blanking (frame-valid low).

## Interface
- RESET_CYCLES, 1000: clocks the sensor reset is held asserted.
- SETTLE_CYCLES, 5000: clocks to wait after reset release before the first register write.
- TRIGGER_CYCLES, 4: snapshot trigger pulse width in clocks (≥1).
- MAX_RETRY, 3: re-issues allowed per write after an I2C NACK.
- ul1Clock  in  1  system clock; all logic in this single domain.
- ul1Resetn  in  1  asynchronous active-low reset.
- ul1Start  in  1  start (or restart) the init sequence; sampled in IDLE and ERROR.
- ul1FrameValid  in  1  sensor frame-valid; asynchronous, 2-flop synchronized internally.
- ul1CamResetn  out  1  to sensor ul1Resetn.
- ul1SnapshotTrigger  out  1  to sensor trigger.
- ul1SnapReq  in  1  single-cycle snapshot request.
- ul1HostWrReq  in  1  host register write request (level, held until ack).
- ul8HostAddr, ul16HostData  in  8/16  host write address and data.
- ul1HostWrAck  out  1  one-cycle pulse: host write completed.
- ul1I2cReq  out  1  write request to I2C master (level).
- ul8I2cAddr, ul16I2cData  out  8/16  register address and data, stable while ul1I2cReq is high.
- ul1I2cDone  in  1  one-cycle completion pulse from the I2C master.
- ul1I2cNack  in  1  qualifies ul1I2cDone; 1 = write failed.
- ul1Ready  out  1  sequencer is in RUN.
- ul1Error  out  1  retries exhausted; sticky until restart.
- ul3State  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, RESET=1, SETTLE=2, CFG_ISSUE=3, CFG_WAIT=4, RUN=5, HOST_WAIT=6, ERROR=7.
- IDLE: ul1CamResetn=0. ul1Start → RESET.
- RESET: ul1CamResetn=0 for RESET_CYCLES, then → SETTLE with ul1CamResetn=1.
- SETTLE: count SETTLE_CYCLES, then → CFG_ISSUE with table index 0.
- CFG_ISSUE: drive table[index]; raise ul1I2cReq → CFG_WAIT.
- CFG_WAIT, on Done with Nack=0:
  - index++ and clear retry count.
  - Last entry → RUN; otherwise → CFG_ISSUE.
- CFG_WAIT, on Done with Nack=1:
  - retry < MAX_RETRY: retry++ and re-issue the same entry.
  - Otherwise → ERROR.
- RUN: ul1Ready=1.
  - A pending host write starts when synced FrameValid=0 → HOST_WAIT (same handshake and retry rules as CFG_WAIT).
  - Host write success → ul1HostWrAck pulse, → RUN.
  - Host write retries exhausted → ERROR with no ack.
- Snapshot:
  - ul1SnapReq sets a pending flag; a further request while pending is merged.
  - In RUN, with synced FrameValid=0, no host write pending and no pulse active, ul1SnapshotTrigger goes high for TRIGGER_CYCLES and the flag clears.
- Priority: host write over snapshot when both are eligible in the same cycle.
- ERROR: ul1Error=1, ul1I2cReq=0, ul1CamResetn stays 1; pending flags cleared. ul1Start → RESET (clears ul1Error).
- Host requests outside RUN are held off; no ack is given until the write is performed.

## Timing
- Reset values: ul1CamResetn=0, ul1SnapshotTrigger=0, ul1I2cReq=0, ul8I2cAddr=0, ul16I2cData=0, ul1HostWrAck=0, ul1Ready=0, ul1Error=0, ul3State=0. Counters, index and flags are cleared.
- Reset asserted mid-operation: everything aborts immediately to the reset values, including dropping ul1I2cReq and the trigger.
- All outputs are registered.
- ul1I2cReq:
  - Rises the cycle after CFG_ISSUE or the host-write start.
  - Falls the cycle after ul1I2cDone.
  - A retry re-raises it after 1 idle cycle.
- FrameValid sync latency is 2 clocks; gating decisions use the synced value only.
- ul1HostWrAck pulses the cycle after ul1I2cDone.
- Counters are sized with $clog2 of their parameter. A counter reaching terminal count leaves its state on the next edge.

## Configuration
- D5M_SNAPSHOT_EN defined: snapshot logic as described above.
- D5M_SNAPSHOT_EN not defined: ul1SnapshotTrigger tied 0, ul1SnapReq ignored, no pending flag or pulse counter synthesized.

## Structure
- Package d5m_pkg holds:
  - the state enum,
  - the config entry struct {addr[7:0], data[15:0]},
  - CFG_DEPTH,
  - the constant CFG_TABLE array (sensor init values).
- Sub-module d5m_sync2: 2-flop synchronizer with async active-low reset, used for ul1FrameValid.

## Test plan
- Reset release, pulse ul1Start, RESET_CYCLES=10, SETTLE_CYCLES=20 → ul1CamResetn low for 10 clocks, then CFG_DEPTH writes in table order, then ul1Ready=1.
- NACK on entry 2 twice, then ACK → entry 2 issued 3 times, sequence completes, ul1Error=0.
- NACK on entry 0 four times with MAX_RETRY=3 → ERROR (ul3State=7, ul1Error=1); ul1Start → reinit succeeds.
- In RUN, host write addr 0x09 data 0x0400 while FrameValid=1 → no ul1I2cReq until FrameValid low + 2 clocks, then one write, then one ack pulse.
- Snapshot request plus host write in the same blanking cycle → I2C write first, then a trigger pulse of exactly 4 clocks. Without D5M_SNAPSHOT_EN the trigger stays 0.
- Assert ul1Resetn mid-CFG_WAIT → all outputs at reset values within the same edge, state 0.
